// File: rtl/fetch_stage.sv
// Fetch stage + 2-entry IF/ID queue: single-outstanding imem handshake, stall hold, redirect flush with DRAIN of in-flight fetch.
// Optional FETCH_STAT_EN adds saturating stall/bubble cycle counters.
module fetch_stage #(
  parameter int                INST_W   = 32,
  parameter int                ADDR_W   = 64,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  output logic              o_imem_req,
  output logic [ADDR_W-1:0] o_imem_addr,
  input  logic              i_imem_valid,
  input  logic [INST_W-1:0] i_imem_inst,
  input  logic              i_stall,
  input  logic              i_redirect,
  input  logic [ADDR_W-1:0] i_redirect_pc,
  output logic              o_id_valid,
  output logic [INST_W-1:0] o_id_inst,
`ifdef FETCH_STAT_EN
  output logic [ADDR_W-1:0] o_id_pc,
  output logic [31:0]       o_stall_cnt,
  output logic [31:0]       o_bubble_cnt
`else
  output logic [ADDR_W-1:0] o_id_pc
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_DRAIN} state_e;

  state_e            state_q;
  logic              req_q;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [1:0]        cnt_q, cnt_d, cnt_pop;
  logic [ADDR_W-1:0] pc0_q, pc0_d, pc1_q, pc1_d;
  logic [INST_W-1:0] inst0_q, inst0_d, inst1_q, inst1_d;
  logic              pop, compl, push;

  always_comb begin
    pop        = (cnt_q != 2'd0) && !i_stall && !i_redirect;
    compl      = req_q && i_imem_valid;
    push       = (state_q == S_REQ) && compl && !i_redirect;
    cnt_pop    = cnt_q - {1'b0, pop};
    cnt_d      = cnt_pop + {1'b0, push};
    fetch_pc_d = fetch_pc_q;
    pc0_d      = pc0_q;
    inst0_d    = inst0_q;
    pc1_d      = pc1_q;
    inst1_d    = inst1_q;
    if (i_redirect) begin
      cnt_d      = 2'd0;
      fetch_pc_d = i_redirect_pc & ~ADDR_W'(3);
    end else begin
      if (pop) begin
        pc0_d   = pc1_q;
        inst0_d = inst1_q;
      end
      // REQ is only held while there is room, so a push never lands at slot 2
      if (push) begin
        if (cnt_pop == 2'd0) begin
          pc0_d   = fetch_pc_q;
          inst0_d = i_imem_inst;
        end else begin
          pc1_d   = fetch_pc_q;
          inst1_d = i_imem_inst;
        end
        fetch_pc_d = fetch_pc_q + ADDR_W'(4);
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= S_IDLE;
      req_q      <= 1'b0;
      addr_q     <= RESET_PC;
      fetch_pc_q <= RESET_PC;
      cnt_q      <= 2'd0;
      pc0_q      <= '0;
      inst0_q    <= '0;
      pc1_q      <= '0;
      inst1_q    <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      cnt_q      <= cnt_d;
      pc0_q      <= pc0_d;
      inst0_q    <= inst0_d;
      pc1_q      <= pc1_d;
      inst1_q    <= inst1_d;
      case (state_q)
        S_IDLE: begin
          if (i_redirect || (cnt_pop < 2'd2)) begin
            state_q <= S_REQ;
            req_q   <= 1'b1;
          end
          addr_q <= fetch_pc_d;
        end
        S_REQ: begin
          if (i_redirect && !compl) begin
            state_q <= S_DRAIN;
          end else if (compl) begin
            // redirect with completion drops the response and refetches at once
            if (i_redirect || (cnt_d < 2'd2)) begin
              state_q <= S_REQ;
              req_q   <= 1'b1;
            end else begin
              state_q <= S_IDLE;
              req_q   <= 1'b0;
            end
            addr_q <= fetch_pc_d;
          end
        end
        S_DRAIN: begin
          // the wrong-path request keeps its address until its response is swallowed
          if (!i_redirect && compl) begin
            state_q <= S_IDLE;
            req_q   <= 1'b0;
            addr_q  <= fetch_pc_q;
          end
        end
        default: begin
          state_q <= S_IDLE;
          req_q   <= 1'b0;
          addr_q  <= fetch_pc_q;
        end
      endcase
    end
  end

  assign o_imem_req  = req_q;
  assign o_imem_addr = addr_q;
  assign o_id_valid  = (cnt_q != 2'd0);
  assign o_id_inst   = o_id_valid ? inst0_q : '0;
  assign o_id_pc     = o_id_valid ? pc0_q : '0;

`ifdef FETCH_STAT_EN
  logic [31:0] stall_cnt_q, bubble_cnt_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      stall_cnt_q  <= '0;
      bubble_cnt_q <= '0;
    end else begin
      if (o_id_valid && i_stall && (stall_cnt_q != 32'hFFFF_FFFF))
        stall_cnt_q <= stall_cnt_q + 32'd1;
      if (!o_id_valid && (bubble_cnt_q != 32'hFFFF_FFFF))
        bubble_cnt_q <= bubble_cnt_q + 32'd1;
    end
  end

  assign o_stall_cnt  = stall_cnt_q;
  assign o_bubble_cnt = bubble_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: latency-programmable memory model, expected-stream scoreboard rebuilt on reset/redirect,
// negedge monitor checking every decode consumption, plus directed checks of the timing corner cases.
module tb_fetch_stage;
  localparam int          INST_W = 32;
  localparam int          ADDR_W = 64;
  localparam logic [63:0] RST_PC = 64'h0;

  logic              i_clk = 1'b0;
  logic              i_rst_n = 1'b0;
  logic              o_imem_req;
  logic [ADDR_W-1:0] o_imem_addr;
  logic              i_imem_valid;
  logic [INST_W-1:0] i_imem_inst;
  logic              i_stall = 1'b0;
  logic              i_redirect = 1'b0;
  logic [ADDR_W-1:0] i_redirect_pc = '0;
  logic              o_id_valid;
  logic [INST_W-1:0] o_id_inst;
  logic [ADDR_W-1:0] o_id_pc;
`ifdef FETCH_STAT_EN
  logic [31:0]       o_stall_cnt, o_bubble_cnt;
`endif

  fetch_stage #(.INST_W(INST_W), .ADDR_W(ADDR_W), .RESET_PC(RST_PC)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .o_imem_req(o_imem_req), .o_imem_addr(o_imem_addr),
    .i_imem_valid(i_imem_valid), .i_imem_inst(i_imem_inst),
    .i_stall(i_stall), .i_redirect(i_redirect), .i_redirect_pc(i_redirect_pc),
    .o_id_valid(o_id_valid), .o_id_inst(o_id_inst),
`ifdef FETCH_STAT_EN
    .o_id_pc(o_id_pc), .o_stall_cnt(o_stall_cnt), .o_bubble_cnt(o_bubble_cnt)
`else
    .o_id_pc(o_id_pc)
`endif
  );

  always #5 i_clk = ~i_clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] inst;
  } exp_t;

  exp_t exp_q[$];

  function automatic logic [31:0] inst_of(input logic [63:0] pc);
    return 32'h0000_0013 + pc[31:0];
  endfunction

  // Decode must see an unbroken sequential run starting at the aligned target
  task automatic restart_stream(input logic [63:0] target);
    logic [63:0] p;
    exp_t        e;
    p = target & ~64'd3;
    exp_q.delete();
    for (int k = 0; k < 512; k++) begin
      e.pc   = p;
      e.inst = inst_of(p);
      exp_q.push_back(e);
      p = p + 64'd4;
    end
  endtask

  // Memory model: accepts a level request, answers after a chosen number of wait cycles
  int          lat_fixed = 0;
  bit          mem_busy  = 1'b0;
  int          mem_wait  = 0;
  int          mem_age   = 0;
  logic [63:0] mem_addr  = '0;

  initial begin
    i_imem_valid = 1'b0;
    i_imem_inst  = '0;
    forever begin
      @(posedge i_clk);
      #1;
      if (!i_rst_n) begin
        mem_busy     = 1'b0;
        mem_age      = 0;
        i_imem_valid = 1'b0;
      end else begin
        if (mem_busy && i_imem_valid) mem_busy = 1'b0;
        if (mem_busy) begin
          chk("req_held", o_imem_req, 1);
          chk("addr_stable", o_imem_addr, mem_addr);
          mem_age++;
        end else if (o_imem_req) begin
          mem_busy = 1'b1;
          mem_addr = o_imem_addr;
          mem_wait = (lat_fixed >= 0) ? lat_fixed : int'($urandom_range(0, 3));
          mem_age  = 0;
        end
        if (mem_busy && mem_wait == 0) begin
          i_imem_valid = 1'b1;
          i_imem_inst  = inst_of(mem_addr);
        end else begin
          i_imem_valid = 1'b0;
          i_imem_inst  = $urandom;
          if (mem_busy) mem_wait--;
        end
      end
    end
  end

  // Monitor: every consumed head entry is popped against the expected stream
  exp_t        mon_e;
  int          consumed = 0;
  logic [31:0] m_stall = 0, m_bubble = 0;

  always @(negedge i_clk) begin
    if (!i_rst_n) begin
      m_stall  <= 0;
      m_bubble <= 0;
    end else begin
      if (o_id_valid) begin
        if (i_stall) m_stall <= m_stall + 1;
        if (!i_stall && !i_redirect) begin
          if (exp_q.size() == 0) begin
            chk("exp_underflow", 1, 0);
          end else begin
            mon_e = exp_q.pop_front();
            chk("id_pc", o_id_pc, mon_e.pc);
            chk("id_inst", {32'h0, o_id_inst}, {32'h0, mon_e.inst});
            consumed++;
          end
        end
      end else begin
        m_bubble <= m_bubble + 1;
        chk("idle_pc_zero", o_id_pc, 0);
        chk("idle_inst_zero", {32'h0, o_id_inst}, 0);
      end
    end
  end

  task automatic tick();
    @(posedge i_clk);
    #2;
  endtask

  task automatic do_redirect(input logic [63:0] pc);
    i_redirect    = 1'b1;
    i_redirect_pc = pc;
    restart_stream(pc);
    tick();
    i_redirect = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_req"}, o_imem_req, 0);
    chk({tag, "_addr"}, o_imem_addr, RST_PC);
    chk({tag, "_valid"}, o_id_valid, 0);
    chk({tag, "_pc"}, o_id_pc, 0);
    chk({tag, "_inst"}, {32'h0, o_id_inst}, 0);
`ifdef FETCH_STAT_EN
    chk({tag, "_stall_cnt"}, {32'h0, o_stall_cnt}, 0);
    chk({tag, "_bubble_cnt"}, {32'h0, o_bubble_cnt}, 0);
`endif
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  logic [63:0] prev_addr, held_pc, old_addr;
  bit          found;
  int          cons0;

  initial begin
    repeat (3) tick();
    chk_reset_outputs("reset");
    restart_stream(RST_PC);
    i_rst_n = 1'b1;

    tick();
    chk("first_req", o_imem_req, 1);
    chk("first_addr", o_imem_addr, RST_PC);
    chk("first_valid", o_id_valid, 0);

    // zero-wait streaming: one per cycle, address one step ahead of decode
    prev_addr = o_imem_addr;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("tput_valid", o_id_valid, 1);
      chk("tput_lead", o_id_pc, prev_addr);
      prev_addr = o_imem_addr;
    end

    i_stall = 1'b1;
    held_pc = o_id_pc;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("stall_valid", o_id_valid, 1);
      chk("stall_hold_pc", o_id_pc, held_pc);
    end
    chk("stall_req_drop", o_imem_req, 0);
    i_stall = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("unstall_no_gap", o_id_valid, 1);
    end

    // redirect in the second wait cycle of a 3-wait fetch
    lat_fixed = 3;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      tick();
      if (o_imem_req && mem_busy && mem_age == 1 && !i_imem_valid) found = 1'b1;
    end
    chk("drain_setup", found, 1);
    old_addr = o_imem_addr;
    do_redirect(64'h100);
    chk("drain_valid", o_id_valid, 0);
    chk("drain_req", o_imem_req, 1);
    chk("drain_addr_held", o_imem_addr, old_addr);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      tick();
      if (o_imem_req && o_imem_addr == 64'h100) found = 1'b1;
    end
    chk("refetch_at_100", found, 1);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      tick();
      if (o_id_valid) found = 1'b1;
    end
    chk("target_presented", found, 1);
    chk("target_pc", o_id_pc, 64'h100);

    // redirect coinciding with completion
    lat_fixed = 2;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      tick();
      if (o_imem_req && i_imem_valid) found = 1'b1;
    end
    chk("samecycle_setup", found, 1);
    do_redirect(64'h203);
    chk("samecycle_addr", o_imem_addr, 64'h200);
    chk("samecycle_req", o_imem_req, 1);
    chk("samecycle_empty", o_id_valid, 0);
    repeat (10) tick();

    // address wrap at the top of the space
    lat_fixed = 0;
    repeat (6) tick();
    do_redirect(64'hFFFF_FFFF_FFFF_FFF8);
    chk("wrap_a0", o_imem_addr, 64'hFFFF_FFFF_FFFF_FFF8);
    tick();
    chk("wrap_a1", o_imem_addr, 64'hFFFF_FFFF_FFFF_FFFC);
    tick();
    chk("wrap_zero", o_imem_addr, 64'h0);
    chk("wrap_req", o_imem_req, 1);
    repeat (5) tick();

    // asynchronous reset between edges
    chk("pre_reset_valid", o_id_valid, 1);
    @(posedge i_clk);
    #3;
    i_rst_n = 1'b0;
    #1;
    chk_reset_outputs("async_reset");
    restart_stream(RST_PC);
    tick();
    i_rst_n = 1'b1;
    tick();
    chk("rerun_req", o_imem_req, 1);
    chk("rerun_addr", o_imem_addr, RST_PC);

    // randomized traffic
    lat_fixed = -1;
    cons0 = consumed;
    for (int c = 0; c < 1500; c++) begin
      i_stall = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 23) == 0) begin
        i_redirect    = 1'b1;
        i_redirect_pc = {$urandom, $urandom};
        restart_stream(i_redirect_pc);
      end else begin
        i_redirect = 1'b0;
      end
      tick();
    end
    i_redirect = 1'b0;
    i_stall    = 1'b0;
    chk("random_progress", (consumed - cons0) > 150, 1);
    repeat (10) tick();
`ifdef FETCH_STAT_EN
    chk("stall_cnt", {32'h0, o_stall_cnt}, {32'h0, m_stall});
    chk("bubble_cnt", {32'h0, o_bubble_cnt}, {32'h0, m_bubble});
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
